// File: rtl/neo_pattern_sequencer.sv
// neo_pattern_sequencer: walks a frame-organised pattern table and drives the
// NeoPixel controller's load/send handshake in loop, one-shot or bounce order.
module neo_pattern_sequencer #(
    parameter int PIX_W   = 3,
    parameter int LEVEL_W = 8,
    parameter int DEPTH   = 64,
    parameter int HOLD_W  = 12,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [AW:0]        frame_len,
    input  logic [AW:0]        num_frames,
    input  logic [HOLD_W-1:0]  hold_sends,
    output logic [AW-1:0]      entry_addr,
    input  logic [PIX_W-1:0]   entry_pixel,
    input  logic [1:0]         entry_color,
    input  logic [LEVEL_W-1:0] entry_level,
    input  logic               ready_to_load,
    input  logic               ready_to_send,
    input  logic               done_wait,
    output logic               load_color,
    output logic [PIX_W-1:0]   pixel_index,
    output logic [1:0]         color_index,
    output logic [LEVEL_W-1:0] color_level,
    output logic               send_it,
    output logic               busy,
    output logic               frame_done,
    output logic               seq_done,
    output logic [AW:0]        cur_frame
);
    typedef enum logic [2:0] {IDLE, LOAD, ARM, SEND, NEXT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [AW:0]       len_q, len_d, nfr_q, nfr_d, f_q, f_d, base_q, base_d, idx_q, idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d, sc_q, sc_d;
    logic              dir_q, dir_d;
    logic [2*AW+1:0]   total;
    logic [HOLD_W:0]   sc_inc;
    logic              cfg_ok, last_f, go_up;

    assign total  = frame_len * num_frames;
    assign cfg_ok = (frame_len != '0) && (num_frames != '0) && (total <= (2*AW+2)'(DEPTH));
    assign sc_inc = {1'b0, sc_q} + 1'b1;
    assign last_f = f_q == nfr_q - (AW+1)'(1);
    // bounce direction after any turn-around at either end of the frame range
    assign go_up  = dir_q ? (f_q == '0) : !last_f;

    assign busy        = state_q != IDLE;
    assign entry_addr  = busy ? AW'(base_q + idx_q) : '0;
    assign cur_frame   = busy ? f_q : '0;
    assign pixel_index = load_color ? entry_pixel : '0;
    assign color_level = load_color ? entry_level : '0;
    assign color_index = (load_color && entry_color != 2'd3) ? entry_color : 2'd0;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        nfr_d      = nfr_q;
        hold_d     = hold_q;
        f_d        = f_q;
        base_d     = base_q;
        idx_d      = idx_q;
        sc_d       = sc_q;
        dir_d      = dir_q;
        load_color = 1'b0;
        send_it    = 1'b0;
        frame_done = 1'b0;
        seq_done   = 1'b0;
        case (state_q)
            IDLE: if (enable && cfg_ok) begin
                state_d = LOAD;
                mode_d  = mode;
                len_d   = frame_len;
                nfr_d   = num_frames;
                hold_d  = hold_sends;
                f_d     = '0;
                base_d  = '0;
                idx_d   = '0;
                sc_d    = '0;
                dir_d   = 1'b0;
            end
            LOAD: if (ready_to_load) begin
                load_color = 1'b1;
                idx_d      = (idx_q == len_q - (AW+1)'(1)) ? '0 : idx_q + 1'b1;
                state_d    = (idx_q == len_q - (AW+1)'(1)) ? ARM : LOAD;
            end
            ARM: if (ready_to_send) begin
                send_it = 1'b1;
                state_d = SEND;
            end
            SEND: if (done_wait) begin
                // hold_sends of 0 still yields one send: sc_inc is never below 1
                state_d = (sc_inc >= {1'b0, hold_q}) ? NEXT : ARM;
                sc_d    = (sc_inc >= {1'b0, hold_q}) ? sc_q : sc_q + 1'b1;
            end
            NEXT: begin
                frame_done = 1'b1;
                sc_d       = '0;
                state_d    = enable ? LOAD : IDLE;
                if (mode_q == 2'b10) begin
                    if (nfr_q != (AW+1)'(1)) begin
                        dir_d  = !go_up;
                        f_d    = go_up ? f_q + 1'b1 : f_q - 1'b1;
                        base_d = go_up ? base_q + len_q : base_q - len_q;
                    end
                end else if (last_f) begin
                    f_d      = '0;
                    base_d   = '0;
                    seq_done = mode_q == 2'b01;
                    state_d  = (mode_q == 2'b01 || !enable) ? IDLE : LOAD;
                end else begin
                    f_d    = f_q + 1'b1;
                    base_d = base_q + len_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= '0;
            len_q   <= '0;
            nfr_q   <= '0;
            hold_q  <= '0;
            f_q     <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            sc_q    <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            nfr_q   <= nfr_d;
            hold_q  <= hold_d;
            f_q     <= f_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            sc_q    <= sc_d;
            dir_q   <= dir_d;
        end
    end
endmodule

// File: tb/tb_neo_pattern_sequencer.sv
// tb_neo_pattern_sequencer: randomized handshake stimulus scored against an
// event-list model of the frame order, loads and sends.
module tb_neo_pattern_sequencer;
    localparam int PIX_W = 3, LEVEL_W = 8, DEPTH = 64, HOLD_W = 12, AW = 6;

    logic               clock = 1'b0;
    logic               reset, enable;
    logic [1:0]         mode;
    logic [AW:0]        frame_len, num_frames;
    logic [HOLD_W-1:0]  hold_sends;
    logic [AW-1:0]      entry_addr;
    logic [PIX_W-1:0]   entry_pixel;
    logic [1:0]         entry_color;
    logic [LEVEL_W-1:0] entry_level;
    logic               ready_to_load, ready_to_send, done_wait;
    logic               load_color, send_it, busy, frame_done, seq_done;
    logic [PIX_W-1:0]   pixel_index;
    logic [1:0]         color_index;
    logic [LEVEL_W-1:0] color_level;
    logic [AW:0]        cur_frame;

    logic [PIX_W-1:0]   tbl_pix [DEPTH];
    logic [1:0]         tbl_col [DEPTH];
    logic [LEVEL_W-1:0] tbl_lvl [DEPTH];

    assign entry_pixel = tbl_pix[entry_addr];
    assign entry_color = tbl_col[entry_addr];
    assign entry_level = tbl_lvl[entry_addr];

    neo_pattern_sequencer dut (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode),
        .frame_len(frame_len), .num_frames(num_frames), .hold_sends(hold_sends),
        .entry_addr(entry_addr), .entry_pixel(entry_pixel), .entry_color(entry_color),
        .entry_level(entry_level), .ready_to_load(ready_to_load), .ready_to_send(ready_to_send),
        .done_wait(done_wait), .load_color(load_color), .pixel_index(pixel_index),
        .color_index(color_index), .color_level(color_level), .send_it(send_it),
        .busy(busy), .frame_done(frame_done), .seq_done(seq_done), .cur_frame(cur_frame)
    );

    always #5 clock = ~clock;

    typedef struct {int kind; int addr; int frame; bit last; int idx; bit seq;} ev_t;
    ev_t exp_q[$];
    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, required %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1; enable = 1'b0; done_wait = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Expected event stream: frame order from closed-form rules, then loads, sends, boundary.
    task automatic build(input int md, input int fl, input int nf, input int hs, input int nk);
        int fr, p;
        for (int k = 0; k < nk; k++) begin
            p  = 2 * (nf - 1);
            fr = (md == 2 && nf > 1) ? ((k % p) < nf ? k % p : p - (k % p)) : k % nf;
            for (int i = 0; i < fl; i++) exp_q.push_back('{0, fr * fl + i, fr, k == nk - 1, i, 1'b0});
            for (int s = 0; s < (hs > 1 ? hs : 1); s++) exp_q.push_back('{1, 0, fr, k == nk - 1, 0, 1'b0});
            exp_q.push_back('{2, 0, fr, k == nk - 1, 0, md == 1 && k == nf - 1});
        end
    endtask

    task automatic run_seq(input int md, input int fl, input int nf, input int hs, input int nk,
                           input bit stall, input int dmax);
        ev_t e;
        int cyc = 0, dcnt = 0;
        bit started = 0, fin = 0, stop = 0;
        logic [1:0] c;
        build(md, fl, nf, hs, nk);
        mode = 2'(md); frame_len = 7'(fl); num_frames = 7'(nf); hold_sends = 12'(hs);
        enable = 1'b1;
        while (!stop) begin
            @(posedge clock); #1;
            ready_to_load = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            ready_to_send = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            done_wait = 1'b0;
            if (dcnt > 0) begin dcnt--; done_wait = (dcnt == 0); end
            if (started) begin
                mode = 2'($urandom); frame_len = 7'($urandom);
                num_frames = 7'($urandom); hold_sends = 12'($urandom);
            end
            @(negedge clock);
            cyc++;
            if (fin) begin
                check("end_busy", 32'(busy), 0);
                check("end_pending", exp_q.size(), 0);
                enable = 1'b0;
                stop = 1;
            end else begin
                if (busy) started = 1;
                if (load_color) begin
                    if (exp_q.size() == 0) check("extra_load", 32'(load_color), 0);
                    else begin
                        e = exp_q.pop_front();
                        c = tbl_col[e.addr];
                        check("load_order", 0, e.kind);
                        check("load_addr", entry_addr, e.addr);
                        check("load_pixel", pixel_index, tbl_pix[e.addr]);
                        check("load_cidx", color_index, c == 2'd3 ? 0 : c);
                        check("load_level", color_level, tbl_lvl[e.addr]);
                        check("load_frame", cur_frame, e.frame);
                        check("load_ready", 32'(ready_to_load), 1);
                        if (md != 1 && e.last && e.idx == (fl > 1 ? 1 : 0)) enable = 1'b0;
                    end
                end
                if (send_it) begin
                    if (exp_q.size() == 0) check("extra_send", 32'(send_it), 0);
                    else begin
                        e = exp_q.pop_front();
                        check("send_order", 1, e.kind);
                        check("send_frame", cur_frame, e.frame);
                        check("send_ready", 32'(ready_to_send), 1);
                        dcnt = stall ? $urandom_range(1, dmax) : dmax;
                    end
                end
                if (frame_done) begin
                    if (exp_q.size() == 0) check("extra_frame_done", 32'(frame_done), 0);
                    else begin
                        e = exp_q.pop_front();
                        check("fdone_order", 2, e.kind);
                        check("fdone_frame", cur_frame, e.frame);
                        check("fdone_seq", 32'(seq_done), 32'(e.seq));
                        fin = e.last;
                    end
                end else if (seq_done) check("stray_seq_done", 32'(seq_done), 0);
                if (cyc > 4000) begin
                    check("timeout_pending", exp_q.size(), 0);
                    stop = 1;
                end
            end
        end
        do_reset();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_load"}, 32'(load_color), 0);
        check({tag, "_send"}, 32'(send_it), 0);
        check({tag, "_addr"}, entry_addr, 0);
        check({tag, "_frame"}, cur_frame, 0);
        check({tag, "_fdone"}, 32'(frame_done | seq_done), 0);
    endtask

    initial begin
        int md, fl, nf, nk, sends;
        bit any_busy, saw;
        for (int i = 0; i < DEPTH; i++) begin
            tbl_pix[i] = 3'($urandom); tbl_col[i] = 2'($urandom); tbl_lvl[i] = 8'($urandom);
        end
        reset = 1'b1; enable = 1'b0; mode = 0; frame_len = 4; num_frames = 3; hold_sends = 1;
        ready_to_load = 1'b1; ready_to_send = 1'b1; done_wait = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_idle("reset");

        run_seq(0, 4, 3, 2, 4, 0, 5);
        run_seq(1, 2, 2, 0, 2, 0, 5);
        run_seq(2, 1, 3, 1, 6, 0, 5);
        run_seq(3, 16, 4, 1, 5, 0, 2);
        run_seq(0, 3, 2, 1, 3, 1, 4);
        for (int r = 0; r < 10; r++) begin
            md = $urandom_range(0, 3);
            fl = $urandom_range(1, 8);
            nf = $urandom_range(1, 6);
            nk = (md == 1) ? nf : $urandom_range(2, 7);
            run_seq(md, fl, nf, $urandom_range(0, 3), nk, 1, 6);
        end

        for (int t = 0; t < 2; t++) begin
            frame_len = (t == 0) ? 7'd40 : 7'd0;
            num_frames = (t == 0) ? 7'd2 : 7'd3;
            enable = 1'b1;
            any_busy = 0;
            repeat (20) begin
                @(negedge clock);
                any_busy |= busy;
            end
            check("invalid_cfg_busy", 32'(any_busy), 0);
            enable = 1'b0;
        end

        mode = 0; frame_len = 2; num_frames = 2; hold_sends = 1;
        ready_to_load = 1'b1; ready_to_send = 1'b1; done_wait = 1'b1; enable = 1'b1;
        sends = 0; saw = 0;
        for (int i = 0; i < 50 && !saw; i++) begin
            @(negedge clock);
            if (send_it) sends++;
            saw = sends == 2;
        end
        check("rst_reached_send", 32'(saw), 1);
        @(posedge clock); #1;
        done_wait = 1'b0;
        @(negedge clock);
        check("rst_in_send_frame", cur_frame, 1);
        check("rst_in_send_addr", entry_addr, 2);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check_idle("rst_mid");
        enable = 1'b0;
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
